// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fru_state_e       : fetch sequencer states (REQ / WAIT / DRAIN)
//   FRU_RESET_VECTOR  : default PC after reset
//   FRU_PC_INC        : sequential fetch stride
//   FRU_NOP           : instruction word presented to decode out of reset
//   fru_align_pc()    : forces a redirect target onto a word boundary
package fetch_redirect_unit_pkg;

    typedef enum logic [1:0] {
        FRU_REQ   = 2'd0,  // free to issue a fetch
        FRU_WAIT  = 2'd1,  // one fetch outstanding, its data is wanted
        FRU_DRAIN = 2'd2   // one fetch outstanding, its data will be thrown away
    } fru_state_e;

    localparam logic [31:0] FRU_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] FRU_PC_INC       = 32'd4;
    localparam logic [31:0] FRU_NOP          = 32'h0000_0013;

    function automatic logic [31:0] fru_align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_flush_ctr.sv
// Flush pulse stretcher for the fetch front end.
//   clk   : core clock
//   rst_n : synchronous reset, active-low
//   load  : redirect seen this cycle; (re)starts the count
//   flush : high while the count is non-zero
module fetch_flush_ctr #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic flush
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(FLUSH_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign flush = (count_q != '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end. Holds the PC, issues one outstanding fetch at a
// time to instruction memory, hands {pc, instr} to decode and follows redirects
// from execute, discarding any fetch that was already in flight.
//   FRU_CLOCK_50 / FRU_RESET_InLow         : clock, synchronous active-low reset
//   FRU_redirect_en / FRU_redirect_pc_InBUS : taken branch / jump and its target
//   FRU_stall                               : decode is not accepting
//   FRU_imem_req_* / FRU_imem_addr_OutBUS   : fetch request channel
//   FRU_imem_rsp_*                          : fetch response (one per request, in order)
//   FRU_if_*                                : fetched instruction to decode
//   FRU_flush                               : squash younger stages after a redirect
//   FRU_misalign                            : redirect target was not word aligned
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = FRU_RESET_VECTOR,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        FRU_CLOCK_50,
    input  logic        FRU_RESET_InLow,
    input  logic        FRU_redirect_en,
    input  logic [31:0] FRU_redirect_pc_InBUS,
    input  logic        FRU_stall,
    output logic        FRU_imem_req_valid,
    input  logic        FRU_imem_req_ready,
    output logic [31:0] FRU_imem_addr_OutBUS,
    input  logic        FRU_imem_rsp_valid,
    input  logic [31:0] FRU_imem_rsp_data_InBUS,
    output logic        FRU_if_valid,
    output logic [31:0] FRU_if_pc_OutBUS,
    output logic [31:0] FRU_if_instr_OutBUS,
    output logic        FRU_flush,
    output logic        FRU_misalign
);

    fru_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic        capture;

    always_ff @(posedge FRU_CLOCK_50) begin
        if (!FRU_RESET_InLow) begin
            state_q <= FRU_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d            = state_q;
        FRU_imem_req_valid = 1'b0;
        capture            = 1'b0;
        unique case (state_q)
            FRU_REQ: begin
                // Only fetch when the output register is free or about to drain;
                // nothing is requested while reset is held.
                FRU_imem_req_valid = FRU_RESET_InLow && (!FRU_if_valid || !FRU_stall);
                if (FRU_imem_req_valid && FRU_imem_req_ready) begin
                    // A request accepted in the redirect cycle targets the old
                    // PC, so its response is already stale.
                    state_d = FRU_redirect_en ? FRU_DRAIN : FRU_WAIT;
                end
            end
            FRU_WAIT: begin
                if (FRU_imem_rsp_valid) begin
                    capture = !FRU_redirect_en;
                    state_d = FRU_REQ;
                end else if (FRU_redirect_en) begin
                    state_d = FRU_DRAIN;
                end
            end
            FRU_DRAIN: begin
                // A redirect here changes nothing: the owed response is
                // discarded either way.
                if (FRU_imem_rsp_valid) begin
                    state_d = FRU_REQ;
                end
            end
            default: state_d = FRU_REQ;
        endcase
    end

    // PC and the decode-facing output register. Redirect outranks both the
    // capture of returning data and the stall hold.
    always_ff @(posedge FRU_CLOCK_50) begin
        if (!FRU_RESET_InLow) begin
            pc_q                <= RESET_VECTOR;
            FRU_if_valid        <= 1'b0;
            FRU_if_pc_OutBUS    <= 32'h0000_0000;
            FRU_if_instr_OutBUS <= FRU_NOP;
            FRU_misalign        <= 1'b0;
        end else begin
            FRU_misalign <= FRU_redirect_en && (FRU_redirect_pc_InBUS[1:0] != 2'b00);
            if (FRU_redirect_en) begin
                pc_q         <= fru_align_pc(FRU_redirect_pc_InBUS);
                FRU_if_valid <= 1'b0;
            end else if (capture) begin
                FRU_if_valid        <= 1'b1;
                FRU_if_pc_OutBUS    <= pc_q;
                FRU_if_instr_OutBUS <= FRU_imem_rsp_data_InBUS;
                pc_q                <= pc_q + FRU_PC_INC;
            end else if (!FRU_stall) begin
                FRU_if_valid <= 1'b0;
            end
        end
    end

    assign FRU_imem_addr_OutBUS = pc_q;

    fetch_flush_ctr #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_ctr (
        .clk   (FRU_CLOCK_50),
        .rst_n (FRU_RESET_InLow),
        .load  (FRU_redirect_en),
        .flush (FRU_flush)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RV       = 32'h0000_0000;
    localparam int          FLUSH_N  = 2;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn, redir, stall, ready, rv;
    logic [31:0] tgt, rdata;
    logic        req_valid, if_valid, flush, misalign;
    logic [31:0] addr, if_pc, if_instr;

    int checks   = 0;
    int failures = 0;

    // Reference model: an "owed response" flag plus a "that response is stale"
    // flag, the architectural PC and the decode-facing register contents.
    logic [31:0] m_pc, m_ifpc, m_ifinstr;
    logic        m_owed, m_drop, m_ifv, m_mis;
    int          m_fl;

    always #5 clk = ~clk;

    fetch_redirect_unit #(
        .RESET_VECTOR(RV),
        .FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .FRU_CLOCK_50            (clk),
        .FRU_RESET_InLow         (rstn),
        .FRU_redirect_en         (redir),
        .FRU_redirect_pc_InBUS   (tgt),
        .FRU_stall               (stall),
        .FRU_imem_req_valid      (req_valid),
        .FRU_imem_req_ready      (ready),
        .FRU_imem_addr_OutBUS    (addr),
        .FRU_imem_rsp_valid      (rv),
        .FRU_imem_rsp_data_InBUS (rdata),
        .FRU_if_valid            (if_valid),
        .FRU_if_pc_OutBUS        (if_pc),
        .FRU_if_instr_OutBUS     (if_instr),
        .FRU_flush               (flush),
        .FRU_misalign            (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic req_expected);
        logic accept, rsp, deliver;
        if (!rstn) begin
            m_pc = RV; m_owed = 1'b0; m_drop = 1'b0; m_ifv = 1'b0;
            m_ifpc = 32'h0; m_ifinstr = NOP_WORD; m_mis = 1'b0; m_fl = 0;
            return;
        end
        accept  = req_expected && ready;
        rsp     = m_owed && rv;
        deliver = rsp && !m_drop && !redir;
        if (rsp) begin
            m_owed = 1'b0;
            m_drop = 1'b0;
        end else if (m_owed && redir) begin
            m_drop = 1'b1;
        end
        if (accept) begin
            m_owed = 1'b1;
            m_drop = redir;
        end
        m_mis = redir && (tgt[1:0] != 2'b00);
        m_fl  = redir ? FLUSH_N : ((m_fl > 0) ? m_fl - 1 : 0);
        if (redir) begin
            m_pc  = {tgt[31:2], 2'b00};
            m_ifv = 1'b0;
        end else if (deliver) begin
            m_ifv     = 1'b1;
            m_ifpc    = m_pc;
            m_ifinstr = rdata;
            m_pc      = m_pc + 32'd4;
        end else if (!stall) begin
            m_ifv = 1'b0;
        end
    endtask

    // One clock: compare every output at the falling edge, then advance the
    // model on the rising edge with the same inputs the DUT sampled.
    task automatic cyc();
        logic exp_req;
        @(negedge clk);
        exp_req = rstn && !m_owed && (!m_ifv || !stall);
        check("req_valid", {31'b0, req_valid}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", addr, m_pc);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
        if (m_ifv) begin
            check("if_pc", if_pc, m_ifpc);
            check("if_instr", if_instr, m_ifinstr);
        end
        check("flush", {31'b0, flush}, {31'b0, (m_fl != 0)});
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
        @(posedge clk);
        model_edge(exp_req);
        #1;
    endtask

    task automatic issue(input logic [31:0] exp_addr);
        ready = 1'b1;
        #1;
        check("dir_req_valid", {31'b0, req_valid}, 32'd1);
        check("dir_addr", addr, exp_addr);
        cyc();
        ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        rv    = 1'b1;
        rdata = data;
        cyc();
        rv = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir = 1'b1;
        tgt   = target;
        cyc();
        redir = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; redir = 1'b0; stall = 1'b0; ready = 1'b0; rv = 1'b0;
        tgt = 32'h0; rdata = 32'h0;

        // Reset: first edge only initialises the model, the next one is checked.
        @(posedge clk);
        model_edge(1'b0);
        #1;
        cyc();
        rstn = 1'b1;
        #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr_nop", if_instr, NOP_WORD);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_addr", addr, RV);

        // 1: back-to-back sequential fetches
        issue(32'h0);  respond(32'hAAAA_0000);
        check("t1_if_pc0", if_pc, 32'h0);
        check("t1_instr0", if_instr, 32'hAAAA_0000);
        issue(32'h4);  respond(32'hAAAA_0004);
        issue(32'h8);  respond(32'hAAAA_0008);

        // 2: stall holds the output register and blocks new requests
        stall = 1'b1;
        #1;
        check("t2_req_blocked", {31'b0, req_valid}, 32'd0);
        cyc(); cyc();
        check("t2_hold_valid", {31'b0, if_valid}, 32'd1);
        check("t2_hold_pc", if_pc, 32'h8);
        stall = 1'b0;
        issue(32'hC);  respond(32'hAAAA_000C);

        // 3: redirect while waiting; late data is dropped, flush lasts two cycles
        issue(32'h10);
        redirect_to(32'h100);
        check("t3_flush_1", {31'b0, flush}, 32'd1);
        respond(32'hDEAD_BEEF);
        check("t3_flush_2", {31'b0, flush}, 32'd1);
        check("t3_no_deliver", {31'b0, if_valid}, 32'd0);
        issue(32'h100);
        check("t3_flush_off", {31'b0, flush}, 32'd0);
        respond(32'hBBBB_0100);
        check("t3_pc", if_pc, 32'h100);

        // 4: misaligned target
        redirect_to(32'h102);
        check("t4_misalign_on", {31'b0, misalign}, 32'd1);
        cyc();
        check("t4_misalign_off", {31'b0, misalign}, 32'd0);
        issue(32'h100); respond(32'hBBBB_0101);

        // 5: PC wraps at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        issue(32'hFFFF_FFFC); respond(32'hCCCC_FFFC);
        check("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        issue(32'h0); respond(32'hCCCC_0000);

        // 6: reset while waiting, stray response afterwards is ignored
        issue(32'h4);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        rv = 1'b1; rdata = 32'h5555_5555;
        #1;
        check("t6_addr_rv", addr, RV);
        cyc();
        rv = 1'b0;
        check("t6_stray_ignored", {31'b0, if_valid}, 32'd0);
        issue(RV); respond(32'hEEEE_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn  = ($urandom_range(0, 199) != 0);
            stall = ($urandom_range(0, 9) < 3);
            ready = $urandom_range(0, 1) == 1;
            rv    = m_owed && ($urandom_range(0, 1) == 1);
            rdata = $urandom;
            redir = ($urandom_range(0, 99) < 8);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            cyc();
        end
        rstn = 1'b1; redir = 1'b0; rv = 1'b0; ready = 1'b0; stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
